// File: rtl/downselect_mask_tx_if.sv
// downselect_mask_tx_if: cfg update, commit and AXI-Stream select bundle of the mask transmitter
interface downselect_mask_tx_if;
  logic        cfg_valid;
  logic [10:0] cfg_chan;
  logic        cfg_en;
  logic        cfg_clear;
  logic        cfg_ready;
  logic        commit;
  logic [3:0]  chan_log2;
  logic        busy;
  logic        m_axis_select_tvalid;
  logic [31:0] m_axis_select_tdata;
  logic        m_axis_select_tlast;
  logic        m_axis_select_tready;
  modport master (
    input  cfg_valid, cfg_chan, cfg_en, cfg_clear, commit, chan_log2, m_axis_select_tready,
    output cfg_ready, busy, m_axis_select_tvalid, m_axis_select_tdata, m_axis_select_tlast
  );
  modport slave (
    output cfg_valid, cfg_chan, cfg_en, cfg_clear, commit, chan_log2, m_axis_select_tready,
    input  cfg_ready, busy, m_axis_select_tvalid, m_axis_select_tdata, m_axis_select_tlast
  );
endinterface

// File: rtl/downselect_mask_tx.sv
// downselect_mask_tx: 2048-bit channel mask store streamed as 32-bit AXI-Stream frames on commit
module downselect_mask_tx (
  input logic clk,
  input logic sync_reset,
  downselect_mask_tx_if.master bus
);
  localparam int MAX_WORDS = 64;
  typedef enum logic [1:0] {CLEAR, IDLE, SEND} state_t;
  state_t      state_q, state_d;
  logic [5:0]  clr_cnt_q, clr_cnt_d;
  logic        pending_q, pending_d;
  logic        rmw_q, rmw_d;
  logic [10:0] rmw_chan_q, rmw_chan_d;
  logic        rmw_en_q, rmw_en_d;
  logic [6:0]  rd_ptr_q, rd_ptr_d;
  logic [5:0]  last_q, last_d;
  logic        rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic        skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [31:0] tdata_q, tdata_d, skid_data_q, skid_data_d;
  logic [31:0] mem [MAX_WORDS];
  logic [31:0] rd_data, wdata, rmw_word;
  logic [5:0]  rd_addr, waddr, n_last;
  logic [3:0]  cl;
  logic [1:0]  cnt_next;
  logic        cfg_rdy, accept, pop, take, last_pop, enter, issue_send, we;
  always_comb begin
    cfg_rdy = state_q == IDLE && !rmw_q;
    accept = bus.cfg_valid && cfg_rdy;
    pop = tvalid_q && bus.m_axis_select_tready;
    take = pop || !tvalid_q;
    last_pop = pop && tlast_q;
    enter = (pending_q || bus.commit) &&
            ((state_q == IDLE && !rmw_q && !accept) || (state_q == SEND && last_pop));
    cl = bus.chan_log2 > 4'd11 ? 4'd11 : bus.chan_log2 < 4'd6 ? 4'd6 : bus.chan_log2;
    n_last = 6'((7'd1 << (cl - 4'd5)) - 7'd1);
    // reads are only issued when the head/skid pair can absorb them even if the sink stalls
    cnt_next = 2'(tvalid_q) + 2'(skid_vld_q) - 2'(pop) + 2'(rd_vld_q);
    issue_send = state_q == SEND && rd_ptr_q <= {1'b0, last_q} && cnt_next <= 2'd1;
    rd_addr = enter ? 6'd0 : state_q == SEND ? rd_ptr_q[5:0] : bus.cfg_chan[10:5];
    rd_ptr_d = enter ? 7'd1 : issue_send ? rd_ptr_q + 7'd1 : rd_ptr_q;
    last_d = enter ? n_last : last_q;
    rd_vld_d = enter || issue_send;
    rd_last_d = issue_send && rd_ptr_q[5:0] == last_q;
    tvalid_d = take ? skid_vld_q || rd_vld_q : 1'b1;
    tdata_d = !take ? tdata_q : skid_vld_q ? skid_data_q : rd_vld_q ? rd_data : tdata_q;
    tlast_d = !take ? tlast_q : skid_vld_q ? skid_last_q : rd_vld_q && rd_last_q;
    skid_vld_d = take ? skid_vld_q && rd_vld_q : skid_vld_q || rd_vld_q;
    skid_data_d = rd_vld_q ? rd_data : skid_data_q;
    skid_last_d = rd_vld_q ? rd_last_q : skid_last_q;
    rmw_word = rd_data;
    rmw_word[rmw_chan_q[4:0]] = rmw_en_q;
    we = state_q == CLEAR || rmw_q;
    waddr = state_q == CLEAR ? clr_cnt_q : rmw_chan_q[10:5];
    wdata = state_q == CLEAR ? 32'd0 : rmw_word;
    rmw_d = accept && !bus.cfg_clear;
    rmw_chan_d = accept ? bus.cfg_chan : rmw_chan_q;
    rmw_en_d = accept ? bus.cfg_en : rmw_en_q;
    clr_cnt_d = state_q == CLEAR ? clr_cnt_q + 6'd1 : 6'd0;
    pending_d = !enter && (pending_q || bus.commit);
    state_d = state_q == CLEAR ? (clr_cnt_q == 6'd63 ? IDLE : CLEAR) :
              enter ? SEND :
              (accept && bus.cfg_clear) ? CLEAR :
              (state_q == SEND && last_pop) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[rd_addr];
  end
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_q <= CLEAR;
      clr_cnt_q <= '0;
      pending_q <= 1'b0;
      rmw_q <= 1'b0;
      rmw_chan_q <= '0;
      rmw_en_q <= 1'b0;
      rd_ptr_q <= '0;
      last_q <= '0;
      rd_vld_q <= 1'b0;
      rd_last_q <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
      skid_vld_q <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pending_q <= pending_d;
      rmw_q <= rmw_d;
      rmw_chan_q <= rmw_chan_d;
      rmw_en_q <= rmw_en_d;
      rd_ptr_q <= rd_ptr_d;
      last_q <= last_d;
      rd_vld_q <= rd_vld_d;
      rd_last_q <= rd_last_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tdata_q <= tdata_d;
      skid_vld_q <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
    end
  end
  assign bus.cfg_ready = cfg_rdy;
  assign bus.busy = state_q != IDLE || pending_q || rmw_q;
  assign bus.m_axis_select_tvalid = tvalid_q;
  assign bus.m_axis_select_tdata = tdata_q;
  assign bus.m_axis_select_tlast = tlast_q;
endmodule

// File: tb/tb_downselect_mask_tx.sv
// tb_downselect_mask_tx: vector table, directed corner cases and random traffic against a 2048-bit mask model
module tb_downselect_mask_tx;
  logic clk = 1'b0;
  logic sync_reset = 1'b1;
  downselect_mask_tx_if bus();
  downselect_mask_tx dut (.clk(clk), .sync_reset(sync_reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { logic [31:0] d; logic l; int c; } beat_t;
  typedef struct { int kind; int chan; bit en; logic [3:0] cl; int n; logic [31:0] w0; logic [31:0] wl; } vec_t;
  beat_t beats[$];
  logic [2047:0] mask = '0;
  int tests = 0, fails = 0, cycn = 0;
  bit rnd_rdy = 0, stall = 0;
  logic [31:0] hold_d;
  logic hold_l;
  vec_t vecs[16];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int n_of(input int cl);
    return cl <= 6 ? 2 : cl >= 11 ? 64 : 1 << (cl - 5);
  endfunction
  function automatic int lasts();
    int n = 0;
    foreach (beats[i]) n += int'(beats[i].l);
    return n;
  endfunction
  task automatic cyc();
    bus.m_axis_select_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stall) begin
      check("stall_valid", 32'(bus.m_axis_select_tvalid), 1);
      check("stall_data", bus.m_axis_select_tdata, hold_d);
      check("stall_last", 32'(bus.m_axis_select_tlast), 32'(hold_l));
    end
    if (bus.m_axis_select_tvalid) check("cfg_ready_in_send", 32'(bus.cfg_ready), 0);
    if (bus.m_axis_select_tvalid && bus.m_axis_select_tready)
      beats.push_back('{bus.m_axis_select_tdata, bus.m_axis_select_tlast, cycn});
    stall = bus.m_axis_select_tvalid && !bus.m_axis_select_tready;
    hold_d = bus.m_axis_select_tdata;
    hold_l = bus.m_axis_select_tlast;
    @(negedge clk);
    cycn++;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 300) begin cyc(); n++; end
    check({nm, "_idle"}, 32'(bus.busy), 0);
  endtask
  task automatic cfg_op(input int chan, input bit en, input bit clr);
    int n = 0;
    bus.cfg_valid = 1'b1; bus.cfg_chan = 11'(chan); bus.cfg_en = en; bus.cfg_clear = clr;
    while (!bus.cfg_ready && n < 300) begin cyc(); n++; end
    check("cfg_accept", 32'(bus.cfg_ready), 1);
    cyc();
    bus.cfg_valid = 1'b0; bus.cfg_clear = 1'b0;
    if (clr) mask = '0;
    else mask[chan] = en;
  endtask
  task automatic frames(input int k, input string nm);
    int n = 0;
    while (lasts() < k && n < 1000) begin cyc(); n++; end
    check({nm, "_frames_seen"}, 32'(lasts() >= k), 1);
  endtask
  task automatic commit_idle(input logic [3:0] cl, input string nm);
    wait_idle(nm);
    bus.chan_log2 = cl; bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    check({nm, "_lat1"}, 32'(bus.m_axis_select_tvalid), 0);
    cyc();
    check({nm, "_lat2"}, 32'(bus.m_axis_select_tvalid), 1);
    frames(1, nm);
  endtask
  task automatic check_frame(input string nm, input int n, input bit consec, input logic [2047:0] snap,
                             output int got, output logic [31:0] w0, output logic [31:0] wl);
    beat_t b;
    int first = 0;
    bit done = 0;
    got = 0; w0 = '0; wl = '0;
    while (!done && beats.size() > 0) begin
      b = beats.pop_front();
      if (got == 0) begin first = b.c; w0 = b.d; end
      wl = b.d;
      if (got < 64) check($sformatf("%s_word%0d", nm, got), b.d, snap[32*got +: 32]);
      check($sformatf("%s_tlast%0d", nm, got), 32'(b.l), 32'(got == n - 1));
      if (consec) check($sformatf("%s_gap%0d", nm, got), 32'(b.c - first), 32'(got));
      got++;
      done = b.l;
    end
    check({nm, "_len"}, 32'(got), 32'(n));
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    int got, n;
    logic [31:0] w0, wl;
    logic [2047:0] snap;
    string nm;
    bus.cfg_valid = 0; bus.cfg_chan = '0; bus.cfg_en = 0; bus.cfg_clear = 0;
    bus.commit = 0; bus.chan_log2 = '0; bus.m_axis_select_tready = 1;
    vecs[0]  = '{2, 0, 0, 4'd11, 64, 32'h0, 32'h0};
    vecs[1]  = '{0, 0, 1, 4'd0, 0, 32'h0, 32'h0};
    vecs[2]  = '{0, 31, 1, 4'd0, 0, 32'h0, 32'h0};
    vecs[3]  = '{0, 32, 1, 4'd0, 0, 32'h0, 32'h0};
    vecs[4]  = '{0, 2047, 1, 4'd0, 0, 32'h0, 32'h0};
    vecs[5]  = '{2, 0, 0, 4'd11, 64, 32'h80000001, 32'h80000000};
    vecs[6]  = '{1, 0, 0, 4'd0, 0, 32'h0, 32'h0};
    vecs[7]  = '{0, 3, 1, 4'd0, 0, 32'h0, 32'h0};
    vecs[8]  = '{2, 0, 0, 4'd4, 2, 32'h8, 32'h0};
    vecs[9]  = '{0, 40, 1, 4'd0, 0, 32'h0, 32'h0};
    vecs[10] = '{2, 0, 0, 4'd6, 2, 32'h8, 32'h100};
    vecs[11] = '{0, 127, 1, 4'd0, 0, 32'h0, 32'h0};
    vecs[12] = '{2, 0, 0, 4'd7, 4, 32'h8, 32'h80000000};
    vecs[13] = '{0, 3, 0, 4'd0, 0, 32'h0, 32'h0};
    vecs[14] = '{2, 0, 0, 4'd15, 64, 32'h0, 32'h0};
    vecs[15] = '{2, 0, 0, 4'd9, 16, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(bus.m_axis_select_tvalid), 0);
    check("rst_tlast", 32'(bus.m_axis_select_tlast), 0);
    check("rst_tdata", bus.m_axis_select_tdata, 0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 0);
    check("rst_busy", 32'(bus.busy), 1);
    sync_reset = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin cyc(); n++; end
    check("clear_cycles", 32'(n), 64);
    check("idle_cfg_ready", 32'(bus.cfg_ready), 1);
    for (int i = 0; i < 16; i++) begin
      nm = $sformatf("vec%0d", i);
      if (vecs[i].kind == 0) cfg_op(vecs[i].chan, vecs[i].en, 1'b0);
      else if (vecs[i].kind == 1) cfg_op(0, 1'b0, 1'b1);
      else begin
        commit_idle(vecs[i].cl, nm);
        check_frame(nm, n_of(int'(vecs[i].cl)), 1'b1, mask, got, w0, wl);
        check({nm, "_n"}, 32'(got), 32'(vecs[i].n));
        check({nm, "_w0"}, w0, vecs[i].w0);
        check({nm, "_wlast"}, wl, vecs[i].wl);
      end
    end
    cfg_op(33, 1'b1, 1'b0);
    cfg_op(64, 1'b1, 1'b0);
    cfg_op(255, 1'b1, 1'b0);
    rnd_rdy = 1;
    commit_idle(4'd8, "bp");
    check_frame("bp", 8, 1'b0, mask, got, w0, wl);
    wait_idle("coll");
    bus.chan_log2 = 4'd8; bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    cyc(); cyc();
    bus.commit = 1'b1; cyc(); bus.commit = 1'b0; cyc();
    bus.commit = 1'b1; cyc(); cyc(); bus.commit = 1'b0;
    frames(2, "coll");
    snap = mask;
    check_frame("coll_a", 8, 1'b0, snap, got, w0, wl);
    check_frame("coll_b", 8, 1'b0, snap, got, w0, wl);
    repeat (30) cyc();
    check("coll_no_third", 32'(beats.size()), 0);
    check("coll_busy", 32'(bus.busy), 0);
    rnd_rdy = 0;
    wait_idle("cc");
    bus.chan_log2 = 4'd4;
    bus.cfg_valid = 1'b1; bus.cfg_chan = 11'd5; bus.cfg_en = 1'b1; bus.cfg_clear = 1'b0; bus.commit = 1'b1;
    check("cc_ready", 32'(bus.cfg_ready), 1);
    cyc();
    bus.cfg_valid = 1'b0; bus.commit = 1'b0;
    mask[5] = 1'b1;
    frames(1, "cc");
    check_frame("cc", 2, 1'b1, mask, got, w0, wl);
    check("cc_bit5", 32'(w0[5]), 1);
    cfg_op(0, 1'b0, 1'b1);
    cfg_op(1, 1'b1, 1'b0);
    cfg_op(2, 1'b1, 1'b0);
    commit_idle(4'd4, "rmw");
    check_frame("rmw", 2, 1'b1, mask, got, w0, wl);
    check("rmw_w0", w0, 32'h6);
    cfg_op(0, 1'b0, 1'b1);
    n = 0;
    while (!bus.cfg_ready && n < 200) begin
      bus.commit = n == 3;
      cyc();
      n++;
    end
    bus.commit = 1'b0;
    check("clr_ready_low", 32'(n), 64);
    frames(1, "clr");
    check_frame("clr", 2, 1'b1, mask, got, w0, wl);
    check("clr_w0", w0, 32'h0);
    cfg_op(100, 1'b1, 1'b0);
    wait_idle("mrst");
    bus.chan_log2 = 4'd11; bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    repeat (6) cyc();
    check("mrst_tvalid_pre", 32'(bus.m_axis_select_tvalid), 1);
    #2 sync_reset = 1'b1;
    #1;
    check("mrst_tvalid", 32'(bus.m_axis_select_tvalid), 0);
    check("mrst_busy", 32'(bus.busy), 1);
    check("mrst_cfg_ready", 32'(bus.cfg_ready), 0);
    @(negedge clk);
    sync_reset = 1'b0;
    beats.delete();
    stall = 0;
    mask = '0;
    commit_idle(4'd11, "post_rst");
    check_frame("post_rst", 64, 1'b1, mask, got, w0, wl);
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 99);
      if (n < 60) cfg_op($urandom_range(0, 1) ? $urandom_range(0, 127) : $urandom_range(0, 2047), 1'($urandom_range(0, 1)), 1'b0);
      else if (n < 65) cfg_op(0, 1'b0, 1'b1);
      else begin
        rnd_rdy = 1'($urandom_range(0, 1));
        n = $urandom_range(0, 15);
        nm = $sformatf("rnd%0d", i);
        commit_idle(4'(n), nm);
        check_frame(nm, n_of(n), !rnd_rdy, mask, got, w0, wl);
        rnd_rdy = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/downselect_mask_tx.md
Name: downselect_mask_tx

Overview:
- Transmit end of the channel down-selection mask FIFO interface: holds a 2048-bit channel-enable mask and streams it as 32-bit AXI-Stream words to the channelizer's down-selection stage.
- Software/control logic sets, clears or wipes channel bits through a simple cfg port. A commit pulse then emits a complete mask frame in the format the down-selection receiver expects.
- Sits between the control register block and the down-selection FIFO in the M2 channelizer.

Parameters:
- MAX_WORDS, 64, mask depth in 32-bit words (64 words = 2048 channels); fixed, not to be overridden.

Ports:
- clk  in  1  clock
- sync_reset  in  1  reset
- cfg_valid  in  1  mask update request
- cfg_chan  in  11  channel index to update
- cfg_en  in  1  new value of channel bit (1 = channel passed)
- cfg_clear  in  1  with cfg_valid: zero entire mask (cfg_chan/cfg_en ignored)
- cfg_ready  out  1  update accepted when cfg_valid & cfg_ready
- commit  in  1  single-cycle request to transmit current mask
- chan_log2  in  4  log2 of active channel count (sampled at frame start)
- busy  out  1  high while CLEAR, a pending commit, or SEND is active
- m_axis_select_tvalid  out  1  mask word valid
- m_axis_select_tdata  out  32  mask word
- m_axis_select_tlast  out  1  last word of frame
- m_axis_select_tready  in  1  downstream ready

Behaviour:
- Reset: sync_reset, asynchronous, active-high; clock clk.
- Reset values: m_axis_select_tvalid=0, tlast=0, tdata=0, cfg_ready=0, busy=1, state=CLEAR, pending commit cleared.
- Storage: 64x32 array, RAM-inferable, 1-cycle read latency.
- Bit mapping: channel c lives in word c[10:5], bit c[4:0]. Word k carries mask bits [32k+31:32k]; word k is sent k-th in the frame.
- States:
  - CLEAR: writes zero to words 0..63, one per cycle (64 cycles). cfg_ready=0. Then -> IDLE. Entered on reset exit and on an accepted cfg_clear.
  - IDLE: cfg_ready=1 except during the write cycle of an in-flight read-modify-write.
  - SEND: streams the frame. cfg_ready=0.
- Channel update: read-modify-write over 2 cycles. Read word cfg_chan[10:5] on accept; write the modified bit on the next cycle. Back-to-back accepts to the same word must see the prior write (forward the written word).
- Commit handling:
  - Sets a pending flag, in any state.
  - Pending plus IDLE with no RMW in flight -> SEND; the flag clears on entry.
  - Commit during SEND or CLEAR is remembered: exactly one further frame follows, and multiple commits collapse into one.
  - Commit and cfg accept in the same cycle: the update is included in the frame.
- Frame length N (chan_log2 sampled on SEND entry):
  - chan_log2 <= 6: N = 2.
  - 7..11: N = 2^(chan_log2-5).
  - >11: treated as 11, N = 64.
  - N is never 1: the receiver treats the first beat as frame start and only honours tlast from the second beat onward.
  - Unused high-order words are not sent.
- AXIS rules:
  - tvalid rises 2 cycles after the commit is accepted into SEND.
  - tdata and tlast hold stable while tvalid & ~tready.
  - One beat per cycle under continuous tready (prefetch/skid register required).
  - tlast=1 only on word N-1. After the last handshake, tvalid=0 the next cycle; state -> IDLE, or straight to SEND if a commit is pending.
- busy = (state != IDLE) | pending | RMW in flight.
- Reset mid-frame: tvalid drops immediately (asynchronous). The receiver recovers via its own reset. After reset the mask reads all-zero.

Test Plan:
- Post-reset: release reset, wait for busy=0 (64+ cycles), commit with chan_log2=11 -> 64 words all 0x00000000, tlast only on the 64th, tvalid first at commit+2.
- Set channels 0, 31, 32, 2047 (cfg_en=1), chan_log2=11, commit, tready=1 -> word0=0x80000001, word1=0x00000001, word63=0x80000000, others 0, 64 consecutive beats.
- Small frame: set channel 3, chan_log2=4, commit -> exactly 2 beats, word0=0x00000008, word1=0x00000000 with tlast=1.
- Backpressure: chan_log2=8 (8 words), random tready 50% -> words stay stable while stalled, sequence and tlast on 8th beat unchanged. cfg_ready=0 throughout SEND.
- Commit collisions: three commits during an active frame -> exactly one additional identical frame after the first tlast. Commit plus cfg set of channel 5 in the same IDLE cycle -> frame word0 bit5=1.
- Same-word RMW: back-to-back accepts set channel 1 then channel 2, then cfg_clear -> cfg_ready low 64 cycles. Commit before clear shows 0x00000006, commit after shows 0x00000000.
